// File: rtl/struct_field_unpacker.sv
// struct_field_unpacker
//   Takes packed-struct words (field 0 at the MSBs) and emits them one field
//   per beat, first-declared field first, with valid/ready on both sides.
//   A single holding register lets the next word be taken on the same cycle
//   the final beat of the current word is consumed, so words stream with
//   no bubble.
//   Optional feature: define STRUCT_UNPACK_PARITY_EN to append one extra
//   beat per word (index NUM_FIELDS) that carries the even parity of the
//   whole word.
module struct_field_unpacker #(
   parameter int NUM_FIELDS = 4,
   parameter int FIELD_W    = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [NUM_FIELDS*FIELD_W-1:0]       in_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [FIELD_W-1:0]                  out_field,
   output logic [$clog2(NUM_FIELDS+1)-1:0]     out_idx,
   output logic                                out_last
);

   localparam int IDX_W  = $clog2(NUM_FIELDS+1);
   localparam int WORD_W = NUM_FIELDS*FIELD_W;
`ifdef STRUCT_UNPACK_PARITY_EN
   localparam int LAST_K = NUM_FIELDS;
`else
   localparam int LAST_K = NUM_FIELDS-1;
`endif
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_K);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t                              state_q, state_d;
   logic [WORD_W-1:0]                   hold_q, hold_d;
   logic [IDX_W-1:0]                    k_q, k_d;
   logic [NUM_FIELDS-1:0][FIELD_W-1:0]  fields;
   logic [FIELD_W-1:0]                  sel_field;
   logic                                emit;
   logic                                at_last;
   logic                                beat_fire;
   logic                                capture;

   // Split the held word into fields; field 0 lives at the MSBs.
   for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
      assign fields[i] = hold_q[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W];
   end

   assign emit      = (state_q == EMIT);
   assign at_last   = emit && (k_q == LAST_IDX);
   assign beat_fire = emit && out_ready;
   // Ready depends on out_ready (so a new word can overlap the last beat),
   // but nothing on the output side depends on in_valid.
   assign in_ready  = !emit || (out_ready && at_last);
   assign capture   = in_valid && in_ready;

   // State register: FSM state, beat counter and holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state: capture a word, step through its beats, reload or go idle.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      hold_d  = hold_q;
      if (capture) begin
         // Covers both IDLE and the overlap with the final beat in EMIT.
         hold_d  = in_data;
         k_d     = '0;
         state_d = EMIT;
      end else if (beat_fire) begin
         if (at_last) begin
            k_d     = '0;
            state_d = IDLE;
         end else begin
            k_d = k_q + IDX_W'(1);
         end
      end
   end

   // Field select: pick the field for the current beat (or the parity bit).
   always_comb begin
      sel_field = '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         if (k_q == IDX_W'(i)) sel_field = fields[i];
      end
`ifdef STRUCT_UNPACK_PARITY_EN
      if (k_q == IDX_W'(NUM_FIELDS)) sel_field = FIELD_W'(^hold_q);
`endif
   end

   // Outputs: driven only while a word is held, zero otherwise.
   always_comb begin
      out_valid = emit;
      out_field = emit ? sel_field : '0;
      out_idx   = emit ? k_q : '0;
      out_last  = at_last;
   end

endmodule
